// File: rtl/sram_responder_pkg.sv
// Shared constants and types for sram_responder: default geometry/timing
// (configure) and the FSM/port enumerations (wires).
package configure;
   localparam int sram_depth_log   = 14;
   localparam int sram_wait_states = 0;
endpackage

package wires;
   typedef enum logic [1:0] {IDLE, BUSY, RESP} sram_state_type;
   typedef enum logic {INSTR, DATA} port_type;
endpackage

// File: rtl/sram_responder_if.sv
// One initiator/responder memory port: request fields plus registered completion.
interface sram_responder_if;
   logic        valid;
   logic        instr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic [31:0] rdata;
   logic        ready;

   modport master (output valid, instr, addr, wdata, wstrb, input rdata, ready);
   modport slave  (input valid, instr, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/sram_responder_array.sv
// sram_array: single-port 2^DEPTH_LOG x 32 storage, byte write enables,
// registered read. Storage is never reset.
module sram_array #(
   parameter int DEPTH_LOG = 14
) (
   input  logic                 clock,
   input  logic                 en,
   input  logic [3:0]           we,
   input  logic [DEPTH_LOG-1:0] addr,
   input  logic [31:0]          wdata,
   output logic [31:0]          q
);
   logic [31:0] mem [0:(1<<DEPTH_LOG)-1];

   always_ff @(posedge clock) begin
      if (en) begin
         for (int b = 0; b < 4; b++)
            if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
         if (we == 4'd0) q <= mem[addr];
      end
   end
endmodule

// File: rtl/sram_responder.sv
// sram_responder: arbitrates instruction/data requests onto one single-port SRAM.
// Define SRAM_RESPONDER_ROUND_ROBIN_EN to alternate grants on simultaneous requests.
module sram_responder
   import configure::*;
   import wires::*;
#(
   parameter int DEPTH_LOG   = sram_depth_log,
   parameter int WAIT_STATES = sram_wait_states
) (
   input  logic            clock,
   input  logic            reset,
   sram_responder_if.slave imemory,
   sram_responder_if.slave dmemory
);
   sram_state_type       state, state_nx;
   port_type             grant, tie_grant, port_q, last_grant;
   logic [3:0]           cnt, cnt_nx;
   logic                 accept, access;
   logic [DEPTH_LOG-1:0] addr_q;
   logic [31:0]          wdata_q, q;
   logic [3:0]           wstrb_q;
   logic                 iready, dready, isel, dsel;
   logic                 unused_bits;

`ifdef SRAM_RESPONDER_ROUND_ROBIN_EN
   assign tie_grant = (last_grant == DATA) ? INSTR : DATA;
`else
   assign tie_grant = DATA;
`endif

   assign grant = (imemory.valid && dmemory.valid) ? tie_grant :
                  (dmemory.valid ? DATA : INSTR);

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      accept   = 1'b0;
      access   = 1'b0;
      case (state)
         IDLE: begin
            if (imemory.valid || dmemory.valid) begin
               accept   = 1'b1;
               cnt_nx   = 4'(WAIT_STATES);
               state_nx = BUSY;
            end
         end
         BUSY: begin
            if (cnt != 4'd0) begin
               cnt_nx = cnt - 4'd1;
            end else begin
               access   = 1'b1;
               state_nx = RESP;
            end
         end
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         port_q     <= INSTR;
         addr_q     <= '0;
         wdata_q    <= 32'd0;
         wstrb_q    <= 4'd0;
         last_grant <= INSTR;
         iready     <= 1'b0;
         dready     <= 1'b0;
         isel       <= 1'b0;
         dsel       <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (accept) begin
            port_q  <= grant;
            addr_q  <= (grant == DATA) ? dmemory.addr[DEPTH_LOG+1:2] : imemory.addr[DEPTH_LOG+1:2];
            wdata_q <= (grant == DATA) ? dmemory.wdata : imemory.wdata;
            wstrb_q <= (grant == DATA) ? dmemory.wstrb : imemory.wstrb;
         end
         // ready/select are high only in the RESP cycle that follows the access
         iready <= access && (port_q == INSTR);
         dready <= access && (port_q == DATA);
         isel   <= access && (port_q == INSTR) && (wstrb_q == 4'd0);
         dsel   <= access && (port_q == DATA)  && (wstrb_q == 4'd0);
         if (access) last_grant <= port_q;
      end
   end

   sram_array #(.DEPTH_LOG(DEPTH_LOG)) u_array (
      .clock (clock),
      .en    (access),
      .we    (wstrb_q),
      .addr  (addr_q),
      .wdata (wdata_q),
      .q     (q)
   );

   // Read data is the array's registered word masked by a flopped select,
   // so nothing combinational reaches the outputs from the request inputs.
   assign imemory.ready = iready;
   assign dmemory.ready = dready;
   assign imemory.rdata = isel ? q : 32'd0;
   assign dmemory.rdata = dsel ? q : 32'd0;

   assign unused_bits = ^{imemory.instr, dmemory.instr,
                          imemory.addr[31:DEPTH_LOG+2], imemory.addr[1:0],
                          dmemory.addr[31:DEPTH_LOG+2], dmemory.addr[1:0]};
endmodule

// File: doc/sram_responder.md
# sram_responder

Responder end of the core's instruction/data memory interface. Accepts requests from the `imemory_*` and `dmemory_*` initiator ports and arbitrates them onto one single-port word SRAM. Returns one registered `ready` pulse with read data per request, after a configurable number of wait states. Used as the on-chip memory in SoC tops and benches.

## Interface
- `DEPTH_LOG`, default 14: SRAM holds 2^DEPTH_LOG 32-bit words.
- `WAIT_STATES`, default 0: extra cycles inserted before each access completes (0..15).
- `reset` input 1: asynchronous, active-low.
- `clock` input 1: single clock; everything is rising-edge.
- `imemory_valid` input 1: instruction request valid; held until `imemory_ready`.
- `imemory_instr` input 1: instruction hint; ignored.
- `imemory_addr` input 32: byte address.
- `imemory_wdata` input 32: write data.
- `imemory_wstrb` input 4: byte strobes; 0 means read.
- `imemory_rdata` output 32: read data, valid only while `imemory_ready`=1.
- `imemory_ready` output 1: one-cycle completion pulse.
- `dmemory_valid`, `dmemory_instr`, `dmemory_addr`, `dmemory_wdata`, `dmemory_wstrb`, `dmemory_rdata`, `dmemory_ready`: same set of signals for the data port.

## Operation
- FSM states: IDLE, BUSY, RESP. Reset state is IDLE. Reset values: all outputs 0, wait counter 0, `last_grant`=INSTR.
- IDLE:
  - If any `valid` is high, grant one port.
  - Latch port id, `addr`, `wdata` and `wstrb`; load counter with WAIT_STATES; go to BUSY.
- BUSY:
  - Counter > 0: decrement.
  - Counter = 0: perform the SRAM access at word index `addr[DEPTH_LOG+1:2]`.
    - Read (`wstrb`=0): register the word into the granted port's `rdata`.
    - Write: update only the strobed bytes; the granted `rdata` is 0.
  - In the same cycle, set the granted port's `ready`, update `last_grant`, and go to RESP.
- RESP:
  - `ready`=1 for exactly this cycle, then return to IDLE.
  - `valid` is not sampled in RESP, so a held `valid` is never accepted twice.
- Arbitration when both `valid` are high in IDLE: DATA wins (fixed priority), or round-robin when enabled (see Configuration).
- The port that is not granted keeps its `valid` high and waits; its `ready` and `rdata` stay 0.
- Address bits above DEPTH_LOG+1 and `addr[1:0]` are ignored, so addresses alias (wrap) modulo the SRAM size.
- An initiator dropping `valid` mid-transaction is a protocol violation; the latched request still completes.
- Reset asserted mid-operation: FSM goes to IDLE and `ready`/`rdata` go to 0 immediately. A pending write is lost. SRAM contents are not cleared.

## Timing
- Request throughput: one request in flight; at most one request completes every WAIT_STATES+3 cycles.
- `valid` first high in cycle 0 → sampled at edge 1 → `ready` high in cycle 2+WAIT_STATES.
- The earliest next acceptance is the edge after the RESP cycle.
- `ready` and `rdata` come straight from flops, with no combinational path from inputs.

## Configuration
- `SRAM_RESPONDER_ROUND_ROBIN_EN` defined: on a tie, grant the port opposite `last_grant`. The first tie after reset therefore goes to DATA; a second back-to-back tie goes to INSTR.
- Macro undefined: fixed DATA priority on every tie. `last_grant` is still kept but not used for arbitration.

## Structure
- `configure` package: `sram_depth_log` and `sram_wait_states` constants used as the defaults.
- `wires` package: `sram_state_type` enum (IDLE/BUSY/RESP) and `port_type` enum (INSTR/DATA).
- One sub-module, `sram_array`: single-port, 2^DEPTH_LOG×32, per-byte write enables, registered read, no reset on storage.

## Test plan
- WAIT_STATES=0: DATA write of 0xDEADBEEF, `wstrb`=4'hF, addr 0x40; then DATA read of 0x40 → `ready` in cycle 2 of each request, read `rdata`=0xDEADBEEF.
- Partial write: write 0x000000AA with `wstrb`=4'h1 to 0x40 → readback 0xDEADBEAA. Write with `wstrb`=4'hC leaves the low half unchanged.
- Tie: both ports read in the same cycle with `valid` held → DATA `ready` first. Then:
  - Macro defined: INSTR `ready` 3 cycles later, then DATA first again on a repeat tie wins INSTR.
  - Macro undefined: DATA wins every repeat tie.
- WAIT_STATES=3: single INSTR read → `imemory_ready` exactly in cycle 5, one cycle wide; `dmemory_ready` stays 0.
- Aliasing with DEPTH_LOG=14: write at 0x00010040, read at 0x00000040 → same data.
- Reset pulse (low) in BUSY during a write → `ready` never pulses, FSM is IDLE after release, old SRAM data is still readable.
